// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level controller: runs one START/STOP/WRITE/READ bit per handshake,
// driving open-drain SCL/SDA enables through four timed phases (A..D).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a command; lines hold the last phase-D levels
// ST_A    | phase A of the latched command
// ST_B    | phase B; SCL normally released, arbitration monitored
// ST_C    | phase C; arbitration monitored, READ samples SDA at its end
// ST_D    | phase D; done is raised in its final cycle
module i2c_bit_ctrl #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            cmd,
  input  logic                  din,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  done,
  output logic                  dout,
  output logic                  arb_lost,
  output logic                  busy,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  scl_oe,
  output logic                  sda_oe
);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A    = 3'd1,
    ST_B    = 3'd2,
    ST_C    = 3'd3,
    ST_D    = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [PRESCALE_W-1:0] cnt, cnt_n;
  logic [PRESCALE_W-1:0] presc_q, presc_n;
  logic [1:0]            cmd_q, cmd_n;
  logic                  din_q, din_n;
  logic                  scl_oe_q, scl_n;
  logic                  sda_oe_q, sda_n;
  logic                  dout_q, dout_n;
  logic                  arb_q, arb_n;

  logic                  stall;
  logic                  phase_end;
  logic                  arb_hit;
  logic                  done_now;
  logic                  accept;

  // Line enables {scl_oe, sda_oe} wanted during a given phase of a command.
  function automatic logic [1:0] line_levels(input logic [1:0] c, input logic d,
                                             input state_t ph);
    logic [1:0] lv;
    lv = 2'b00;
    case (c)
      CMD_START: begin
        case (ph)
          ST_A:    lv = 2'b00;
          ST_B:    lv = 2'b00;
          ST_C:    lv = 2'b01;
          ST_D:    lv = 2'b11;
          default: lv = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (ph)
          ST_A:    lv = 2'b11;
          ST_B:    lv = 2'b01;
          ST_C:    lv = 2'b01;
          ST_D:    lv = 2'b00;
          default: lv = 2'b00;
        endcase
      end
      CMD_WRITE: begin
        case (ph)
          ST_A:    lv = {1'b1, ~d};
          ST_B:    lv = {1'b0, ~d};
          ST_C:    lv = {1'b0, ~d};
          ST_D:    lv = {1'b1, ~d};
          default: lv = 2'b00;
        endcase
      end
      default: begin
        case (ph)
          ST_A:    lv = 2'b10;
          ST_B:    lv = 2'b00;
          ST_C:    lv = 2'b00;
          ST_D:    lv = 2'b10;
          default: lv = 2'b00;
        endcase
      end
    endcase
    return lv;
  endfunction

  // A slave holding SCL low while we release it freezes the phase timer.
  assign stall     = !scl_oe_q && !scl_in;
  assign phase_end = (state != ST_IDLE) && (cnt == '0) && !stall;

  // SDA released by our own intent (not a READ) yet seen low: another master won.
  assign arb_hit   = ((state == ST_B) || (state == ST_C)) && !sda_oe_q &&
                     (cmd_q != CMD_READ) && !sda_in && !stall;

  // done fires in the last D cycle so the next command can be accepted in
  // the same cycle; the line levels of that cycle equal the idle levels.
  assign done_now  = !rst && (state == ST_D) && phase_end;
  assign cmd_ready = (state == ST_IDLE) || done_now;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE) && !done_now;

  assign done      = done_now;
  assign dout      = dout_q;
  assign arb_lost  = arb_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

  // Next-state, phase timer and registered line levels.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    presc_n = presc_q;
    cmd_n   = cmd_q;
    din_n   = din_q;
    scl_n   = scl_oe_q;
    sda_n   = sda_oe_q;
    dout_n  = dout_q;
    arb_n   = 1'b0;

    if (state != ST_IDLE) begin
      if (arb_hit) begin
        state_n = ST_IDLE;
        scl_n   = 1'b0;
        sda_n   = 1'b0;
        arb_n   = 1'b1;
      end else if (phase_end) begin
        case (state)
          ST_A:    state_n = ST_B;
          ST_B:    state_n = ST_C;
          ST_C:    state_n = ST_D;
          default: state_n = ST_IDLE;
        endcase
        cnt_n = presc_q;
        if ((state == ST_C) && (cmd_q == CMD_READ)) begin
          dout_n = sda_in;
        end
        if (state != ST_D) begin
          {scl_n, sda_n} = line_levels(cmd_q, din_q, state_n);
        end
      end else if (!stall) begin
        cnt_n = cnt - PRESCALE_W'(1);
      end
    end

    if (accept) begin
      state_n        = ST_A;
      presc_n        = prescale;
      cnt_n          = prescale;
      cmd_n          = cmd;
      din_n          = din;
      {scl_n, sda_n} = line_levels(cmd, din, ST_A);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      presc_q  <= '0;
      cmd_q    <= CMD_START;
      din_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      dout_q   <= 1'b0;
      arb_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      presc_q  <= presc_n;
      cmd_q    <= cmd_n;
      din_q    <= din_n;
      scl_oe_q <= scl_n;
      sda_oe_q <= sda_n;
      dout_q   <= dout_n;
      arb_q    <= arb_n;
    end
  end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Bench for i2c_bit_ctrl: directed scenarios followed by random commands,
// checked cycle by cycle against a timeline model built from phase lengths.
module tb_i2c_bit_ctrl;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] prescale;
  logic [1:0]    cmd;
  logic          din;
  logic          cmd_valid;
  logic          cmd_ready, done, dout, arb_lost, busy;
  logic          scl_in, sda_in, scl_oe, sda_oe;

  logic          stretch_hold = 1'b0;
  logic          sda_drv      = 1'b1;

  int            tests = 0;
  int            fails = 0;
  logic          exp_dout;
  logic [1:0]    exp_idle;

  i2c_bit_ctrl #(.PRESCALE_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .prescale  (prescale),
    .cmd       (cmd),
    .din       (din),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .done      (done),
    .dout      (dout),
    .arb_lost  (arb_lost),
    .busy      (busy),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe)
  );

  always #5 clk = ~clk;

  // Wired-AND pins: a released line reads high unless a slave pulls it low.
  assign scl_in = ~scl_oe & ~stretch_hold;
  assign sda_in = ~sda_oe & sda_drv;

  task automatic chk(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, expv);
    end
  endtask

  // {scl_oe, sda_oe} per phase (0=A .. 3=D) straight from the line table.
  function automatic logic [1:0] spec_lines(input logic [1:0] c, input logic d, input int ph);
    logic [7:0] row;
    case (c)
      2'b00:   row = 8'b00_00_01_11;
      2'b01:   row = 8'b11_01_01_00;
      2'b10:   row = {1'b1, ~d, 1'b0, ~d, 1'b0, ~d, 1'b1, ~d};
      default: row = 8'b10_00_00_10;
    endcase
    return row[7-2*ph -: 2];
  endfunction

  task automatic check_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      #1;
      chk("idle_scl", scl_oe, exp_idle[1]);
      chk("idle_sda", sda_oe, exp_idle[0]);
      chk("idle_ready", cmd_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_arb", arb_lost, 1'b0);
      chk("idle_dout", dout, exp_dout);
    end
  endtask

  // Issue a command in the current cycle and follow it to completion.
  // p: prescale, s: stretch cycles at the start of B, rb: bit the slave
  // returns on READ, arb_k: cycle (after accept) with a foreign SDA low, 0 = none.
  task automatic run_cmd(input logic [1:0] c, input logic d, input int p, input int s,
                         input logic rb, input int arb_k);
    int         lat;
    int         ph;
    int         c_last;
    logic [1:0] ln;
    lat    = 4 * (p + 1) + s;
    c_last = 3 * p + 3 + s;
    chk("ready_pre", cmd_ready, 1'b1);
    prescale  = PW'(p);
    cmd       = c;
    din       = d;
    cmd_valid = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k <= p + 1)                ph = 0;
      else if (k <= 2 * p + 2 + s)   ph = 1;
      else if (k <= c_last)          ph = 2;
      else                           ph = 3;
      cmd_valid    = (k == lat || (arb_k != 0 && k == arb_k + 1)) ? 1'b0 : 1'($urandom_range(0, 1));
      cmd          = 2'($urandom_range(0, 3));
      din          = 1'($urandom_range(0, 1));
      prescale     = PW'($urandom_range(0, 65535));
      stretch_hold = (k >= p + 2 && k <= p + 1 + s);
      if (c == 2'b11)
        sda_drv = (k == c_last) ? rb : 1'($urandom_range(0, 1));
      else
        sda_drv = (arb_k != 0 && k == arb_k) ? 1'b0 : 1'b1;
      #1;
      if (arb_k != 0 && k == arb_k + 1) begin
        chk("arb_pulse", arb_lost, 1'b1);
        chk("arb_scl", scl_oe, 1'b0);
        chk("arb_sda", sda_oe, 1'b0);
        chk("arb_ready", cmd_ready, 1'b1);
        chk("arb_busy", busy, 1'b0);
        chk("arb_done", done, 1'b0);
        break;
      end
      ln = spec_lines(c, d, ph);
      chk("scl_oe", scl_oe, ln[1]);
      chk("sda_oe", sda_oe, ln[0]);
      chk("done", done, k == lat);
      chk("busy", busy, k != lat);
      chk("arb_quiet", arb_lost, 1'b0);
      if (k == lat) begin
        if (c == 2'b11) exp_dout = rb;
        chk("ready_done", cmd_ready, 1'b1);
        chk("dout", dout, exp_dout);
      end
    end
    stretch_hold = 1'b0;
    sda_drv      = 1'b1;
    exp_idle     = (arb_k != 0) ? 2'b00 : spec_lines(c, d, 3);
  endtask

  initial begin
    logic [1:0] c;
    logic       d, rb;
    int         p, s, ak, gap;

    rst       = 1'b1;
    prescale  = '0;
    cmd       = 2'b00;
    din       = 1'b0;
    cmd_valid = 1'b0;
    exp_dout  = 1'b0;
    exp_idle  = 2'b00;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_scl", scl_oe, 1'b0);
      chk("rst_sda", sda_oe, 1'b0);
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_arb", arb_lost, 1'b0);
      chk("rst_dout", dout, 1'b0);
    end
    rst = 1'b0;
    check_idle(2);

    run_cmd(2'b10, 1'b0, 4, 0, 1'b0, 0);
    check_idle(2);

    run_cmd(2'b11, 1'b0, 2, 0, 1'b1, 0);
    check_idle(1);
    run_cmd(2'b11, 1'b0, 2, 0, 1'b0, 0);
    check_idle(1);

    run_cmd(2'b10, 1'b1, 4, 7, 1'b0, 0);
    check_idle(1);

    run_cmd(2'b10, 1'b1, 3, 0, 1'b0, 5);
    check_idle(3);

    run_cmd(2'b00, 1'b0, 0, 0, 1'b0, 0);
    run_cmd(2'b01, 1'b0, 0, 0, 1'b0, 0);

    prescale  = '0;
    cmd       = 2'b10;
    din       = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_scl", scl_oe, 1'b0);
    chk("mid_rst_sda", sda_oe, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_arb", arb_lost, 1'b0);
    exp_dout = 1'b0;
    exp_idle = 2'b00;
    check_idle(2);

    for (int i = 0; i < 40; i++) begin
      c  = 2'($urandom_range(0, 3));
      d  = 1'($urandom_range(0, 1));
      p  = $urandom_range(0, 5);
      s  = $urandom_range(0, 3);
      rb = 1'($urandom_range(0, 1));
      ak = 0;
      if (((c == 2'b10 && d) || c == 2'b00) && $urandom_range(0, 2) == 0)
        ak = p + 2 + s + $urandom_range(0, p);
      run_cmd(c, d, p, s, rb, ak);
      gap = $urandom_range(0, 2);
      if (gap != 0) check_idle(gap);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
